// File: rtl/crc_pkg.sv
// crc_pkg: shared types and defaults for the CRC-8 frame controller
package crc_pkg;
   localparam int CRC_W = 8;
   localparam logic [CRC_W-1:0] DEF_POLY = 8'h1D;
   localparam logic [CRC_W-1:0] DEF_INIT = 8'h00;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/crc_frame_ctrl_lfsr.sv
// crc8_lfsr: serial CRC LFSR, one message bit per enabled clock
module crc8_lfsr
   import crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = DEF_POLY,
   parameter logic [CRC_W-1:0] INIT = DEF_INIT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);
   logic [CRC_W-1:0] crc_q, crc_d;
   logic inv;
   always_comb begin
      inv = bit_in ^ crc_q[CRC_W-1];
      crc_d = clr ? INIT
            : en ? ({crc_q[CRC_W-2:0], inv} ^ ({POLY[CRC_W-1:1], 1'b0} & {CRC_W{inv}}))
            : crc_q;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) crc_q <= INIT;
      else crc_q <= crc_d;
   assign crc = crc_q;
endmodule

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: byte-stream CRC-8 frame sequencer; CRC_CHECK_EN adds crc_ok output
module crc_frame_ctrl
   import crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY      = DEF_POLY,
   parameter logic [CRC_W-1:0] INIT      = DEF_INIT,
   parameter bit               LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [CRC_W-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [CRC_W-1:0] crc_data,
   output logic             crc_valid,
   input  logic             crc_ready,
`ifdef CRC_CHECK_EN
   output logic             crc_ok,
`endif
   output logic             busy
);
   state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [CRC_W-1:0] sh_q, sh_d;
   logic last_q, last_d;
   logic accept, clr, en, bit_in, end_byte;
   always_comb begin
      end_byte = state_q == SHIFT && cnt_q == 3'd7;
      // a follow-on byte may load on the final bit slot so frames stream at 8 cycles/byte
      in_ready = state_q == IDLE || (end_byte && !last_q);
      accept = in_valid && in_ready;
      crc_valid = state_q == DONE;
      clr = crc_valid && crc_ready;
      en = state_q == SHIFT;
      busy = state_q != IDLE;
      bit_in = LSB_FIRST ? sh_q[cnt_q] : sh_q[3'd7 - cnt_q];
      sh_d = accept ? in_data : sh_q;
      last_d = accept ? in_last : last_q;
      cnt_d = accept ? 3'd0 : en ? cnt_q + 3'd1 : cnt_q;
      state_d = accept ? SHIFT
              : clr ? IDLE
              : end_byte ? (last_q ? DONE : IDLE)
              : state_q;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         sh_q <= '0;
         last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         sh_q <= sh_d;
         last_q <= last_d;
      end
   crc8_lfsr #(.POLY(POLY), .INIT(INIT)) u_lfsr (
      .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .bit_in(bit_in), .crc(crc_data)
   );
`ifdef CRC_CHECK_EN
   assign crc_ok = crc_valid && crc_data == '0;
`endif
endmodule
